// File: rtl/snn_infer_ctrl_if.sv
// rtl/snn_infer_ctrl_if.sv - sample start, event stream, spike and result signals of the inference sequencer
// Purpose: bundles every non-clock/reset signal of snn_infer_ctrl.
// Ports (signals):
//   i_start, i_num_events, i_timeout       sample start and per-sample settings
//   i_ev_valid, i_ev_data, o_ev_ready      upstream event word handshake
//   o_event, o_nrn_clear, i_spike          neuron layer side
//   o_busy                                 sequencer busy
//   o_res_valid, i_res_ready, o_res_winner,
//   o_res_hit, o_res_cycles                result handshake and fields
// Modports: master = the sequencer itself, slave = the surrounding logic that drives it.
interface snn_infer_ctrl_if #(
    parameter int P_N     = 4,
    parameter int P_S     = 42,
    parameter int P_CNT_W = 8,
    parameter int P_TMO_W = 16
);
    logic               i_start;
    logic [P_CNT_W-1:0] i_num_events;
    logic [P_TMO_W-1:0] i_timeout;
    logic               i_ev_valid;
    logic [P_S-1:0]     i_ev_data;
    logic               o_ev_ready;
    logic [P_S-1:0]     o_event;
    logic               o_nrn_clear;
    logic [P_N-1:0]     i_spike;
    logic               o_busy;
    logic               o_res_valid;
    logic               i_res_ready;
    logic [P_N-1:0]     o_res_winner;
    logic               o_res_hit;
    logic [P_TMO_W-1:0] o_res_cycles;

    modport master (
        input  i_start, i_num_events, i_timeout, i_ev_valid, i_ev_data, i_spike, i_res_ready,
        output o_ev_ready, o_event, o_nrn_clear, o_busy, o_res_valid, o_res_winner,
        output o_res_hit, o_res_cycles
    );

    modport slave (
        output i_start, i_num_events, i_timeout, i_ev_valid, i_ev_data, i_spike, i_res_ready,
        input  o_ev_ready, o_event, o_nrn_clear, o_busy, o_res_valid, o_res_winner,
        input  o_res_hit, o_res_cycles
    );
endinterface

// File: rtl/snn_infer_ctrl.sv
// rtl/snn_infer_ctrl.sv - per-sample inference sequencer in front of the spiking neuron layer
// Purpose: clears the neuron layer, paces event words into it with a fixed gap, and reports
//          the first-firing neuron (or a timeout) through a valid/ready result port.
// Ports:
//   i_clk  clock
//   i_rst  synchronous reset, active-high
//   bus    snn_infer_ctrl_if.master (start/settings, event stream, spikes, result)
module snn_infer_ctrl #(
    parameter int P_N     = 4,
    parameter int P_S     = 42,
    parameter int P_GAP   = 2,
    parameter int P_CLR   = 2,
    parameter int P_CNT_W = 8,
    parameter int P_TMO_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    snn_infer_ctrl_if.master   bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_FEED   = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_SETTLE = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    // Last value of the shared sub-counter in CLEAR and GAP.
    localparam logic [7:0] L_CLR_LAST = 8'(P_CLR - 1);
    localparam logic [7:0] L_GAP_LAST = 8'(P_GAP - 1);

    logic [2:0]         r_state;
    logic [7:0]         r_sub;
    logic [P_CNT_W-1:0] r_num;
    logic [P_CNT_W-1:0] r_ev_cnt;
    logic [P_TMO_W-1:0] r_tmo_lim;
    logic [P_TMO_W-1:0] r_tmo_cnt;
    logic [P_TMO_W-1:0] r_cyc;
    logic               r_hit;
    logic [P_N-1:0]     r_winner;
    logic [P_TMO_W-1:0] r_res_cyc;
    logic [P_S-1:0]     r_event;

    logic               w_track;
    logic               w_spk_any;
    logic               w_capture;
    logic [P_N-1:0]     w_onehot;
    logic               w_handshake;
    logic [P_CNT_W-1:0] w_ev_next;
    logic [P_TMO_W-1:0] w_cyc_next;

    assign w_track     = (r_state == S_FEED) || (r_state == S_GAP) || (r_state == S_SETTLE);
    assign w_spk_any   = |bus.i_spike;
    assign w_capture   = w_track && !r_hit && w_spk_any;
    // x & -x isolates the lowest set bit, so a tie resolves to the lowest-index neuron.
    assign w_onehot    = bus.i_spike & (~bus.i_spike + P_N'(1));
    assign w_handshake = (r_state == S_FEED) && bus.i_ev_valid;
    assign w_ev_next   = r_ev_cnt + P_CNT_W'(1);
    assign w_cyc_next  = (&r_cyc) ? r_cyc : r_cyc + P_TMO_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_sub     <= '0;
            r_num     <= '0;
            r_ev_cnt  <= '0;
            r_tmo_lim <= '0;
            r_tmo_cnt <= '0;
            r_cyc     <= '0;
            r_hit     <= 1'b0;
            r_winner  <= '0;
            r_res_cyc <= '0;
            r_event   <= '0;
        end else begin
            // The accepted word is shown for exactly one cycle after the handshake.
            r_event <= w_handshake ? bus.i_ev_data : '0;

            if (w_track) begin
                r_cyc <= w_cyc_next;
            end

            if (w_capture) begin
                r_hit     <= 1'b1;
                r_winner  <= w_onehot;
                r_res_cyc <= r_cyc;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_num     <= bus.i_num_events;
                        r_tmo_lim <= bus.i_timeout;
                        r_hit     <= 1'b0;
                        r_winner  <= '0;
                        r_res_cyc <= '0;
                        r_sub     <= '0;
                        r_state   <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (r_sub == L_CLR_LAST) begin
                        r_sub     <= '0;
                        r_ev_cnt  <= '0;
                        r_cyc     <= '0;
                        r_tmo_cnt <= '0;
                        r_state   <= (r_num == '0) ? S_SETTLE : S_FEED;
                    end else begin
                        r_sub <= r_sub + 8'd1;
                    end
                end
                S_FEED: begin
                    if (w_handshake) begin
                        r_ev_cnt <= w_ev_next;
                        if (w_ev_next == r_num) begin
                            r_tmo_cnt <= '0;
                            r_state   <= S_SETTLE;
                        end else if (P_GAP > 0) begin
                            r_sub   <= '0;
                            r_state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (r_sub == L_GAP_LAST) begin
                        r_state <= S_FEED;
                    end else begin
                        r_sub <= r_sub + 8'd1;
                    end
                end
                S_SETTLE: begin
                    r_tmo_cnt <= r_tmo_cnt + P_TMO_W'(1);
                    if (r_hit || w_spk_any) begin
                        r_state <= S_DONE;
                    end else if (r_tmo_cnt == r_tmo_lim) begin
                        r_winner  <= '0;
                        r_res_cyc <= r_cyc;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.i_res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_ev_ready   = (r_state == S_FEED);
    assign bus.o_nrn_clear  = (r_state == S_CLEAR);
    assign bus.o_busy       = (r_state != S_IDLE);
    assign bus.o_res_valid  = (r_state == S_DONE);
    assign bus.o_event      = r_event;
    assign bus.o_res_winner = r_winner;
    assign bus.o_res_hit    = r_hit;
    assign bus.o_res_cycles = r_res_cyc;
endmodule

// File: doc/snn_infer_ctrl.md
Name: snn_infer_ctrl

Overview:
- Per-sample inference sequencer placed in front of the 4-neuron, 42-synapse neuron layer.
- Clears neuron state, paces a stream of 42-bit event words into the layer with a fixed inter-event gap, and watches the layer's spike outputs.
- Reports the first-firing (winner) neuron, or a timeout, through a valid/ready result port.

Parameters:
P_N, 4, number of neurons / spike lines
P_S, 42, synapses per event word
P_GAP, 2, idle cycles inserted after each accepted event (0 allowed)
P_CLR, 2, cycles o_nrn_clear is held high (>=1)
P_CNT_W, 8, width of event count
P_TMO_W, 16, width of timeout and cycle counters

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_start  in  1  start a sample; honoured only in IDLE
i_num_events  in  P_CNT_W  events in this sample, latched on start
i_timeout  in  P_TMO_W  settle timeout in cycles, latched on start
i_ev_valid  in  1  upstream event word valid
i_ev_data  in  P_S  upstream event word
o_ev_ready  out  1  event accepted when i_ev_valid & o_ev_ready
o_event  out  P_S  event word to neuron layer, one-cycle pulse
o_nrn_clear  out  1  neuron state clear
i_spike  in  P_N  spike lines from neuron layer
o_busy  out  1  high in every state except IDLE
o_res_valid  out  1  result valid
i_res_ready  in  1  result consumed
o_res_winner  out  P_N  one-hot winner, 0 if no hit
o_res_hit  out  1  1 = spike seen, 0 = timeout
o_res_cycles  out  P_TMO_W  cycles from first FEED cycle to hit/timeout, saturating

Behaviour:
- Reset (synchronous, i_rst=1 at a clock edge): state IDLE; all outputs 0; counters and latched results cleared. Reset mid-sample aborts it; any accepted-but-not-driven event word is dropped; no result is produced.
- Clock and reset: single clock i_clk; reset is synchronous and active-high on i_rst.
- States: IDLE, CLEAR, FEED, GAP, SETTLE, DONE.
- IDLE:
  - On i_start: latch i_num_events and i_timeout, clear the hit flag, go to CLEAR.
  - i_start is ignored in every other state.
- CLEAR:
  - o_nrn_clear=1 for exactly P_CLR cycles.
  - Then go to FEED, or to SETTLE if the latched count is 0.
  - Start in cycle T gives clear high T+1..T+P_CLR and first FEED cycle T+1+P_CLR.
- FEED:
  - o_ev_ready=1.
  - On handshake: register i_ev_data, drive it on o_event for exactly the next cycle, then drive 0. An all-zero word is accepted and counted.
  - Increment the event counter. If counter == latched count, go to SETTLE; otherwise go to GAP if P_GAP>0, else stay in FEED.
  - Without i_ev_valid, stay in FEED; the cycle counter keeps running.
- GAP: o_ev_ready=0 for P_GAP cycles, then return to FEED.
- Cycle counter:
  - Set to 0 on the first FEED cycle.
  - Increments every cycle in FEED, GAP and SETTLE.
  - Saturates at all-ones.
- Spike capture:
  - Active in FEED, GAP and SETTLE.
  - The first cycle with i_spike != 0 and hit flag clear latches winner = lowest-index set bit (one-hot), hit=1, and the current cycle-counter value.
  - Later spikes are ignored. Spikes in IDLE, CLEAR and DONE are ignored.
  - A hit during FEED/GAP does not stop feeding: all latched events are still consumed, keeping the stream aligned.
- SETTLE:
  - Timeout counter is 0 on entry and increments each cycle.
  - If hit is already set, or i_spike != 0 this cycle (capture applies), go to DONE next cycle.
  - Else if timeout counter == latched timeout, latch hit=0, winner=0, and the cycle-counter value; go to DONE.
  - Timeout 0 means a single SETTLE cycle.
- DONE:
  - o_res_valid=1 and result fields held stable until i_res_ready=1.
  - Then clear o_res_valid and go to IDLE.
  - o_busy falls the same cycle o_res_valid falls.
- Counters never wrap: the event count comparison is exact; the cycle counter saturates.

Test Plan:
- Reset: hold i_rst 3 cycles mid-traffic -> all outputs 0, o_busy=0; an i_start in the same cycle as i_rst is ignored.
- Basic hit: P_GAP=2, P_CLR=2, num=3, timeout=100, i_ev_valid constant, words 0x1/0x2/0x4, first FEED cycle F.
  - Expect o_nrn_clear high F-2..F-1.
  - Expect o_event = 0x1@F+1, 0x2@F+4, 0x4@F+7; SETTLE from F+7.
  - i_spike=4'b0100 at F+11 -> o_res_valid at F+12, winner=0100, hit=1, cycles=11.
- Tie and early hit: i_spike=4'b1010 at F+2, then 4'b0001 at F+5 -> winner=0010, cycles=2; all 3 events still emitted; DONE entered at F+8.
- Timeout: same stimulus, no spikes, timeout=10 -> DONE at F+18, hit=0, winner=0, cycles=17.
- Backpressure:
  - i_ev_valid low for 5 cycles in FEED -> o_event stays 0, cycle counter advances.
  - i_res_ready low for 4 cycles -> result held stable.
  - i_start during busy -> ignored.
  - num=0 -> CLEAR goes straight to SETTLE.
- Reset mid-FEED after 1 of 3 events -> IDLE next cycle, no o_res_valid; a new start runs a clean sample.
